// File: rtl/wb_seq_if.sv
// Writeback sequencer bus: request handshake, data-memory read data and the
// register-file write port with per-register load-pending flags.
interface wb_seq_if #(
  parameter int PW = 2
);
  logic            req_valid;
  logic            req_ready;
  logic            req_is_load;
  logic [PW-1:0]   req_addr;
  logic [7:0]      req_data;
  logic [7:0]      mem_rd_data;
  logic            wr_en;
  logic [PW-1:0]   wr_addr;
  logic [7:0]      wr_data;
  logic [2**PW-1:0] busy;

  modport slave (
    input  req_valid, req_is_load, req_addr, req_data, mem_rd_data,
    output req_ready, wr_en, wr_addr, wr_data, busy
  );

  modport master (
    output req_valid, req_is_load, req_addr, req_data, mem_rd_data,
    input  req_ready, wr_en, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/wb_seq.sv
// Writeback sequencer: ALU results write next cycle, loads wait MEM_LAT cycles
// for memory data. Define WB_OVERLAP_EN to let ALU writes slip in during a load.
module wb_seq #(
  parameter int PW      = 2,
  parameter int MEM_LAT = 2
) (
  input  logic     clk,
  input  logic     reset,
  wb_seq_if.slave  bus
);

  localparam int NR = 2**PW;
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  typedef enum logic {IDLE, LOAD_WAIT} state_e;

  state_e          state_q;
  logic [2:0]      count_q;
  logic [PW-1:0]   pend_addr_q;
  logic            wr_en_q;
  logic [PW-1:0]   wr_addr_q;
  logic [7:0]      wr_data_q;
  logic [NR-1:0]   busy_q;
  logic            ready_d;
  logic            accept;

  always_comb begin
    ready_d = 1'b0;
    case (state_q)
      IDLE: ready_d = 1'b1;
      LOAD_WAIT: begin
`ifdef WB_OVERLAP_EN
        // Never in the count==0 cycle, so ALU and load writes cannot collide.
        ready_d = (count_q != 3'd0) && !bus.req_is_load &&
                  (bus.req_addr != pend_addr_q);
`else
        ready_d = 1'b0;
`endif
      end
      default: ready_d = 1'b0;
    endcase
  end

  assign accept = bus.req_valid && ready_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= 3'd0;
      pend_addr_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      busy_q      <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (bus.req_is_load) begin
              pend_addr_q <= bus.req_addr;
              busy_q      <= NR'(1) << bus.req_addr;
              count_q     <= LAT_M1;
              state_q     <= LOAD_WAIT;
            end else begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= bus.req_addr;
              wr_data_q <= bus.req_data;
            end
          end
        end
        LOAD_WAIT: begin
          if (count_q != 3'd0) begin
            count_q <= count_q - 3'd1;
            if (accept) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= bus.req_addr;
              wr_data_q <= bus.req_data;
            end
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= pend_addr_q;
            wr_data_q <= bus.mem_rd_data;
            busy_q    <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready_d;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_wb_seq.sv
// Bench for wb_seq: directed vectors with literal expectations plus a
// cycle-timed behavioural model compared against the outputs every cycle.
module tb_wb_seq;

  localparam int PW      = 2;
  localparam int MEM_LAT = 2;
  localparam int NR      = 2**PW;
`ifdef WB_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  wb_seq_if #(.PW(PW)) bus ();

  wb_seq #(.PW(PW), .MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: a load accepted in cycle c owns the pending slot for cycles
  // c+1..c+MEM_LAT and writes the memory data seen in cycle c+MEM_LAT.
  bit              m_init = 1'b0;
  int unsigned     n = 0;
  bit              pend_v = 1'b0;
  logic [PW-1:0]   pend_addr;
  int unsigned     pend_due;
  logic            m_en;
  logic [PW-1:0]   m_addr;
  logic [7:0]      m_data;
  logic            exp_rdy;
  logic [NR-1:0]   exp_busy;

  always @(negedge clk) begin
    exp_busy = pend_v ? (NR'(1) << pend_addr) : '0;
    if (pend_v)
      exp_rdy = OVL && (n < pend_due) && !bus.req_is_load && (bus.req_addr != pend_addr);
    else
      exp_rdy = 1'b1;
    if (m_init) begin
      chk("model ready",   32'(bus.req_ready), 32'(exp_rdy));
      chk("model wr_en",   32'(bus.wr_en),     32'(m_en));
      chk("model wr_addr", 32'(bus.wr_addr),   32'(m_addr));
      chk("model wr_data", 32'(bus.wr_data),   32'(m_data));
      chk("model busy",    32'(bus.busy),      32'(exp_busy));
      chk("busy onehot",   32'($countones(bus.busy) <= 1), 32'd1);
    end
    if (reset) begin
      m_init = 1'b1;
      m_en   = 1'b0;
      m_addr = '0;
      m_data = 8'h00;
      pend_v = 1'b0;
    end else if (m_init) begin
      m_en = 1'b0;
      if (pend_v && n == pend_due) begin
        m_en   = 1'b1;
        m_addr = pend_addr;
        m_data = bus.mem_rd_data;
        pend_v = 1'b0;
      end else if (bus.req_valid && exp_rdy) begin
        if (bus.req_is_load) begin
          pend_v    = 1'b1;
          pend_addr = bus.req_addr;
          pend_due  = n + MEM_LAT;
        end else begin
          m_en   = 1'b1;
          m_addr = bus.req_addr;
          m_data = bus.req_data;
        end
      end
    end
    n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic [PW-1:0] a, input logic [7:0] d);
    bus.req_valid   = v;
    bus.req_is_load = ld;
    bus.req_addr    = a;
    bus.req_data    = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc_prev;
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 8'h00);
    bus.mem_rd_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst wr_en",   32'(bus.wr_en),     32'd0);
    chk("rst wr_addr", 32'(bus.wr_addr),   32'd0);
    chk("rst wr_data", 32'(bus.wr_data),   32'h00);
    chk("rst busy",    32'(bus.busy),      32'h0);
    chk("rst ready",   32'(bus.req_ready), 32'd1);

    // Back-to-back ALU writes
    tick(); drive(1'b1, 1'b0, 2'd1, 8'h5A);
    @(negedge clk); chk("alu c0 ready", 32'(bus.req_ready), 32'd1);
    tick(); drive(1'b1, 1'b0, 2'd2, 8'hC3);
    @(negedge clk);
    chk("alu c1 wr_en", 32'(bus.wr_en), 32'd1);
    chk("alu c1 addr",  32'(bus.wr_addr), 32'd1);
    chk("alu c1 data",  32'(bus.wr_data), 32'h5A);
    tick(); drive(1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    chk("alu c2 wr_en", 32'(bus.wr_en), 32'd1);
    chk("alu c2 addr",  32'(bus.wr_addr), 32'd2);
    chk("alu c2 data",  32'(bus.wr_data), 32'hC3);
    tick();
    @(negedge clk);
    chk("alu c3 wr_en", 32'(bus.wr_en), 32'd0);
    chk("alu c3 hold",  32'(bus.wr_data), 32'hC3);

    // Load to r3, data arrives in cycle 2
    tick(); drive(1'b1, 1'b1, 2'd3, 8'h00); bus.mem_rd_data = 8'h00;
    @(negedge clk);
    tick(); bus.req_valid = 1'b0; bus.mem_rd_data = 8'h11;
    @(negedge clk);
    chk("ld c1 busy",  32'(bus.busy), 32'h8);
    chk("ld c1 ready", 32'(bus.req_ready), 32'd0);
    tick(); bus.mem_rd_data = 8'h7E;
    @(negedge clk);
    chk("ld c2 busy",  32'(bus.busy), 32'h8);
    chk("ld c2 ready", 32'(bus.req_ready), 32'd0);
    chk("ld c2 wr_en", 32'(bus.wr_en), 32'd0);
    tick(); bus.mem_rd_data = 8'h22;
    @(negedge clk);
    chk("ld c3 wr_en", 32'(bus.wr_en), 32'd1);
    chk("ld c3 addr",  32'(bus.wr_addr), 32'd3);
    chk("ld c3 data",  32'(bus.wr_data), 32'h7E);
    chk("ld c3 busy",  32'(bus.busy), 32'h0);

    // Load to r3 followed by a held ALU request to r1
    tick(); drive(1'b1, 1'b1, 2'd3, 8'h00); bus.mem_rd_data = 8'h9C;
    @(negedge clk);
    tick(); drive(1'b1, 1'b0, 2'd1, 8'h11);
    @(negedge clk);
`ifdef WB_OVERLAP_EN
    chk("ovl c1 ready", 32'(bus.req_ready), 32'd1);
    tick(); drive(1'b1, 1'b0, 2'd3, 8'h33);
    @(negedge clk);
    chk("ovl c2 wr_en", 32'(bus.wr_en), 32'd1);
    chk("ovl c2 addr",  32'(bus.wr_addr), 32'd1);
    chk("ovl c2 data",  32'(bus.wr_data), 32'h11);
    chk("ovl c2 ready", 32'(bus.req_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("ovl c3 addr",  32'(bus.wr_addr), 32'd3);
    chk("ovl c3 data",  32'(bus.wr_data), 32'h9C);
    chk("ovl c3 ready", 32'(bus.req_ready), 32'd1);
    tick(); drive(1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    chk("ovl c4 wr_en", 32'(bus.wr_en), 32'd1);
    chk("ovl c4 addr",  32'(bus.wr_addr), 32'd3);
    chk("ovl c4 data",  32'(bus.wr_data), 32'h33);
`else
    chk("hold c1 ready", 32'(bus.req_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("hold c2 ready", 32'(bus.req_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("hold c3 ready", 32'(bus.req_ready), 32'd1);
    chk("hold c3 addr",  32'(bus.wr_addr), 32'd3);
    chk("hold c3 data",  32'(bus.wr_data), 32'h9C);
    tick(); drive(1'b0, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    chk("hold c4 wr_en", 32'(bus.wr_en), 32'd1);
    chk("hold c4 addr",  32'(bus.wr_addr), 32'd1);
    chk("hold c4 data",  32'(bus.wr_data), 32'h11);
`endif

    // Reset aborts a pending load to r2
    tick(); drive(1'b1, 1'b1, 2'd2, 8'h00);
    @(negedge clk);
    tick(); bus.req_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("abort c1 busy", 32'(bus.busy), 32'h4);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("abort c2 busy",  32'(bus.busy), 32'h0);
    chk("abort c2 ready", 32'(bus.req_ready), 32'd1);
    chk("abort c2 wr_en", 32'(bus.wr_en), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("abort no write", 32'(bus.wr_en), 32'd0);
    end

    // Register 0 as ALU and load destination
    tick(); drive(1'b1, 1'b0, 2'd0, 8'hA5);
    @(negedge clk);
    tick(); drive(1'b1, 1'b1, 2'd0, 8'h00); bus.mem_rd_data = 8'h3C;
    @(negedge clk);
    chk("r0 alu addr", 32'(bus.wr_addr), 32'd0);
    chk("r0 alu data", 32'(bus.wr_data), 32'hA5);
    tick(); bus.req_valid = 1'b0;
    @(negedge clk);
    chk("r0 ld busy", 32'(bus.busy), 32'h1);
    repeat (2) tick();
    @(negedge clk);
    chk("r0 ld wr_en", 32'(bus.wr_en), 32'd1);
    chk("r0 ld data",  32'(bus.wr_data), 32'h3C);

    // Mixed traffic with held requests, checked by the model
    acc_prev = 1'b1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (acc_prev || !bus.req_valid)
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
              PW'($urandom_range(0, NR - 1)), 8'($urandom));
      bus.mem_rd_data = 8'($urandom);
      @(negedge clk);
      acc_prev = bus.req_valid && bus.req_ready;
    end
    tick(); bus.req_valid = 1'b0;
    repeat (MEM_LAT + 3) tick();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
